// File: rtl/instr_mem_loader_pkg.sv
// Shared types and constants for the loadable instruction memory.
// Holds the loader state enum, the invalid-word read value and depth.
package instr_mem_loader_pkg;

  localparam int DEF_DEPTH_WORDS = 64;

  localparam logic [31:0] INSTR_NOP = 32'h0;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    DONE = 2'd2
  } ld_state_t;

endpackage

// File: rtl/instr_word_ram.sv
// Word storage with per-word valid bits: sync write, async read.
// Ports: clk, rst, clr_all, we/waddr/wdata, raddr -> rdata/rvalid.
module instr_word_ram #(
  parameter int DEPTH_WORDS = 64,
  parameter int IDX_W       = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr_all,
  input  logic             we,
  input  logic [IDX_W-1:0] waddr,
  input  logic [31:0]      wdata,
  input  logic [IDX_W-1:0] raddr,
  output logic [31:0]      rdata,
  output logic             rvalid
);

  logic [31:0]            mem [DEPTH_WORDS];
  logic [DEPTH_WORDS-1:0] valid_q;

  // Data array is deliberately not reset; valid bits gate reads.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= '0;
    end else if (clr_all) begin
      valid_q <= '0;
    end else if (we) begin
      valid_q[waddr] <= 1'b1;
    end
  end

  assign rdata  = mem[raddr];
  assign rvalid = valid_q[raddr];

endmodule

// File: rtl/instr_mem_loader.sv
// Writable instruction memory fed by a little-endian byte stream.
// Ports: load_start/len, byte handshake, PC->Instruction, stall/done/err.
module instr_mem_loader
  import instr_mem_loader_pkg::*;
#(
  parameter int DEPTH_WORDS = DEF_DEPTH_WORDS,
  parameter int IDX_W       = 6
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load_start,
  input  logic [15:0] load_len,
  input  logic        byte_valid,
  input  logic [7:0]  byte_data,
  output logic        byte_ready,
  input  logic [31:0] PC,
  output logic [31:0] Instruction,
  output logic        cpu_stall,
  output logic        load_done,
  output logic        load_err
);

  ld_state_t        state_q;
  ld_state_t        state_d;
  logic [1:0]       byte_cnt_q;
  logic [IDX_W-1:0] word_idx_q;
  logic [15:0]      len_q;
  logic [23:0]      shreg_q;
  logic             load_err_q;

  logic             start_ok;
  logic             len_zero;
  logic             len_big;
  logic             begin_load;
  logic             xfer;
  logic             last_byte;
  logic             last_word;

  logic [IDX_W-1:0] ridx;
  logic             pc_hi_ok;
  logic [31:0]      rdata;
  logic             rvalid;
  logic             unused_pc_lo;

  assign start_ok   = (state_q == IDLE) && load_start;
  assign len_zero   = (load_len == 16'd0);
  assign len_big    = 32'(load_len) > DEPTH_WORDS;
  assign begin_load = start_ok && !len_zero && !len_big;

  // byte_ready is high throughout LOAD, so valid alone means a transfer.
  assign xfer      = (state_q == LOAD) && byte_valid;
  assign last_byte = xfer && (byte_cnt_q == 2'd3);
  assign last_word = (16'(word_idx_q) + 16'd1) == len_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (load_start) begin
          if (len_zero) begin
            state_d = DONE;
          end else if (!len_big) begin
            state_d = LOAD;
          end
        end
      end
      LOAD: begin
        if (last_byte && last_word) begin
          state_d = DONE;
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    byte_ready = 1'b0;
    cpu_stall  = 1'b0;
    load_done  = 1'b0;
    unique case (state_q)
      IDLE: ;
      LOAD: begin
        byte_ready = 1'b1;
        cpu_stall  = 1'b1;
      end
      DONE: begin
        cpu_stall = 1'b1;
        load_done = 1'b1;
      end
      default: ;
    endcase
  end

  // Bytes shift in from the top, so after three bytes
  // shreg_q holds {b2, b1, b0} and the fourth completes the word.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      byte_cnt_q <= '0;
      word_idx_q <= '0;
      len_q      <= '0;
      shreg_q    <= '0;
      load_err_q <= 1'b0;
    end else begin
      load_err_q <= start_ok && !len_zero && len_big;
      if (begin_load) begin
        len_q      <= load_len;
        word_idx_q <= '0;
        byte_cnt_q <= '0;
        shreg_q    <= '0;
      end else if (xfer) begin
        byte_cnt_q <= byte_cnt_q + 2'd1;
        shreg_q    <= {byte_data, shreg_q[23:8]};
        if (byte_cnt_q == 2'd3) begin
          word_idx_q <= word_idx_q + 1'b1;
        end
      end
    end
  end

  assign load_err = load_err_q;

  assign ridx         = PC[IDX_W+1:2];
  assign pc_hi_ok     = (PC[31:IDX_W+2] == '0);
  assign unused_pc_lo = ^PC[1:0];

  instr_word_ram #(
    .DEPTH_WORDS (DEPTH_WORDS),
    .IDX_W       (IDX_W)
  ) u_ram (
    .clk     (clk),
    .rst     (rst),
    .clr_all (begin_load),
    .we      (last_byte),
    .waddr   (word_idx_q),
    .wdata   ({byte_data, shreg_q}),
    .raddr   (ridx),
    .rdata   (rdata),
    .rvalid  (rvalid)
  );

  // Reads are blanked outside IDLE, which also hides same-cycle writes.
  always_comb begin
    Instruction = INSTR_NOP;
    if ((state_q == IDLE) && pc_hi_ok && rvalid) begin
      Instruction = rdata;
    end
  end

endmodule

// File: tb/tb_instr_mem_loader.sv
// Directed bench for instr_mem_loader: loads, gaps, bounds, resets.
// Drives and samples on the falling edge; DUT acts on the rising edge.
module tb_instr_mem_loader;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        load_start = 1'b0;
  logic [15:0] load_len = '0;
  logic        byte_valid = 1'b0;
  logic [7:0]  byte_data = '0;
  logic        byte_ready;
  logic [31:0] PC = '0;
  logic [31:0] Instruction;
  logic        cpu_stall;
  logic        load_done;
  logic        load_err;

  int pass_cnt = 0;
  int total_cnt = 0;

  logic [7:0] prog [256];
  int st;
  int dn;
  int acc;

  always #5 clk = ~clk;

  instr_mem_loader dut (
    .clk         (clk),
    .rst         (rst),
    .load_start  (load_start),
    .load_len    (load_len),
    .byte_valid  (byte_valid),
    .byte_data   (byte_data),
    .byte_ready  (byte_ready),
    .PC          (PC),
    .Instruction (Instruction),
    .cpu_stall   (cpu_stall),
    .load_done   (load_done),
    .load_err    (load_err)
  );

  // Issue a load and stream prog[] with `gap` idle cycles after each
  // accepted byte. Reports stall cycles, cycle of load_done (-1 if
  // never seen) and bytes accepted when load_done was seen.
  // At byte index start_at, load_start is pulsed with load_len=1.
  task automatic run_load(input int nw, input int gap,
                          input int start_at, output int s,
                          output int d, output int a);
    int idx = 0;
    int gapc = 0;
    bit fin = 0;
    @(negedge clk);
    load_start = 1'b1;
    load_len   = 16'(nw);
    @(negedge clk);
    load_start = 1'b0;
    s = 0;
    d = -1;
    a = -1;
    for (int c = 0; c < 3000 && !fin; c++) begin
      if (cpu_stall) s++;
      if (load_done) begin
        d = s;
        a = idx;
        fin = 1;
      end else if (!cpu_stall) begin
        fin = 1;
      end else begin
        load_start = (idx == start_at);
        if (idx == start_at) load_len = 16'd1;
        if (gapc > 0) begin
          byte_valid = 1'b0;
          gapc--;
        end else if (idx < nw * 4) begin
          byte_valid = 1'b1;
          byte_data  = prog[idx];
          if (byte_ready) begin
            idx++;
            gapc = gap;
          end
        end else begin
          byte_valid = 1'b0;
        end
        @(negedge clk);
      end
    end
    byte_valid = 1'b0;
    load_start = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    logic [31:0] pcs [3] = '{32'd0, 32'd4, 32'd252};
    rst = 1'b1;
    @(negedge clk);
    total_cnt++;
    if ({cpu_stall, byte_ready, load_done, load_err} !== 4'b0)
      $display("FAIL rst_outs got %b exp 0000",
               {cpu_stall, byte_ready, load_done, load_err});
    else pass_cnt++;
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      PC = pcs[i];
      #1;
      total_cnt++;
      if (Instruction !== 32'h0 || cpu_stall !== 1'b0
          || byte_ready !== 1'b0)
        $display("FAIL rst_fetch pc=%h got %h/%b/%b exp 0/0/0",
                 PC, Instruction, cpu_stall, byte_ready);
      else pass_cnt++;
    end
  endtask

  task automatic set_two_words();
    logic [7:0] b [8] = '{8'h14, 8'h00, 8'hA0, 8'hE3,
                          8'h01, 8'h1A, 8'hA0, 8'hE3};
    for (int i = 0; i < 8; i++) prog[i] = b[i];
  endtask

  task automatic test_load_two();
    logic [31:0] pcs [4] = '{32'd0, 32'd4, 32'd8, 32'd2};
    logic [31:0] exps [4] = '{32'hE3A00014, 32'hE3A01A01,
                              32'h0, 32'hE3A00014};
    set_two_words();
    run_load(2, 0, -1, st, dn, acc);
    total_cnt++;
    if (st !== 9 || dn !== 9)
      $display("FAIL ld2_timing got stall=%0d done=%0d exp 9/9",
               st, dn);
    else pass_cnt++;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      PC = pcs[i];
      #1;
      total_cnt++;
      if (Instruction !== exps[i])
        $display("FAIL ld2_read pc=%h got %h exp %h",
                 PC, Instruction, exps[i]);
      else pass_cnt++;
    end
  endtask

  task automatic test_back_pressure();
    logic [31:0] pcs [3] = '{32'd0, 32'd4, 32'd8};
    logic [31:0] exps [3] = '{32'hE3A00014, 32'hE3A01A01, 32'h0};
    set_two_words();
    run_load(2, 3, -1, st, dn, acc);
    total_cnt++;
    if (acc !== 8 || dn !== 30 || st !== 30)
      $display("FAIL gap_timing got acc=%0d done=%0d stall=%0d exp 8/30/30",
               acc, dn, st);
    else pass_cnt++;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      PC = pcs[i];
      #1;
      total_cnt++;
      if (Instruction !== exps[i])
        $display("FAIL gap_read pc=%h got %h exp %h",
                 PC, Instruction, exps[i]);
      else pass_cnt++;
    end
  endtask

  task automatic test_len_zero();
    @(negedge clk);
    load_start = 1'b1;
    load_len   = 16'd0;
    @(negedge clk);
    load_start = 1'b0;
    total_cnt++;
    if (load_done !== 1'b1 || cpu_stall !== 1'b1)
      $display("FAIL len0_done got done=%b stall=%b exp 1/1",
               load_done, cpu_stall);
    else pass_cnt++;
    @(negedge clk);
    PC = 32'd4;
    #1;
    total_cnt++;
    if (load_done !== 1'b0 || cpu_stall !== 1'b0
        || Instruction !== 32'hE3A01A01)
      $display("FAIL len0_after got done=%b stall=%b ins=%h exp 0/0/e3a01a01",
               load_done, cpu_stall, Instruction);
    else pass_cnt++;
  endtask

  task automatic test_len_err();
    @(negedge clk);
    load_start = 1'b1;
    load_len   = 16'd65;
    @(negedge clk);
    load_start = 1'b0;
    total_cnt++;
    if (load_err !== 1'b1 || cpu_stall !== 1'b0 || byte_ready !== 1'b0)
      $display("FAIL len65_err got err=%b stall=%b rdy=%b exp 1/0/0",
               load_err, cpu_stall, byte_ready);
    else pass_cnt++;
    @(negedge clk);
    PC = 32'd0;
    #1;
    total_cnt++;
    if (load_err !== 1'b0 || load_done !== 1'b0
        || Instruction !== 32'hE3A00014)
      $display("FAIL len65_after got err=%b done=%b ins=%h exp 0/0/e3a00014",
               load_err, load_done, Instruction);
    else pass_cnt++;
  endtask

  task automatic test_full_depth();
    logic [31:0] pcs [5] = '{32'd0, 32'd252, 32'd256,
                             32'h8000_0000, 32'd128};
    logic [31:0] exps [5] = '{32'hC0FF5A00, 32'hC0C05A3F, 32'h0,
                              32'h0, 32'hC0DF5A20};
    for (int i = 0; i < 64; i++) begin
      prog[4*i]   = 8'(i);
      prog[4*i+1] = 8'h5A;
      prog[4*i+2] = ~8'(i);
      prog[4*i+3] = 8'hC0;
    end
    run_load(64, 0, -1, st, dn, acc);
    total_cnt++;
    if (st !== 257 || dn !== 257)
      $display("FAIL len64_timing got stall=%0d done=%0d exp 257/257",
               st, dn);
    else pass_cnt++;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      PC = pcs[i];
      #1;
      total_cnt++;
      if (Instruction !== exps[i])
        $display("FAIL len64_read pc=%h got %h exp %h",
                 PC, Instruction, exps[i]);
      else pass_cnt++;
    end
  endtask

  task automatic test_reload();
    logic [31:0] pcs [3] = '{32'd0, 32'd4, 32'd8};
    logic [31:0] exp3 [3] = '{32'h44332211, 32'h88776655,
                              32'hCCBBAA99};
    logic [31:0] exp1 [3] = '{32'hEFBEADDE, 32'h0, 32'h0};
    for (int i = 0; i < 12; i++) prog[i] = 8'(8'h11 * (i + 1));
    run_load(3, 0, 6, st, dn, acc);
    total_cnt++;
    if (st !== 13 || dn !== 13 || acc !== 12)
      $display("FAIL rl3_timing got stall=%0d done=%0d acc=%0d exp 13/13/12",
               st, dn, acc);
    else pass_cnt++;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      PC = pcs[i];
      #1;
      total_cnt++;
      if (Instruction !== exp3[i])
        $display("FAIL rl3_read pc=%h got %h exp %h",
                 PC, Instruction, exp3[i]);
      else pass_cnt++;
    end
    prog[0] = 8'hDE;
    prog[1] = 8'hAD;
    prog[2] = 8'hBE;
    prog[3] = 8'hEF;
    run_load(1, 0, -1, st, dn, acc);
    total_cnt++;
    if (st !== 5 || dn !== 5)
      $display("FAIL rl1_timing got stall=%0d done=%0d exp 5/5", st, dn);
    else pass_cnt++;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      PC = pcs[i];
      #1;
      total_cnt++;
      if (Instruction !== exp1[i])
        $display("FAIL rl1_read pc=%h got %h exp %h",
                 PC, Instruction, exp1[i]);
      else pass_cnt++;
    end
  endtask

  task automatic test_reset_midload();
    for (int i = 0; i < 16; i++) prog[i] = 8'(8'hA0 + i);
    @(negedge clk);
    load_start = 1'b1;
    load_len   = 16'd4;
    @(negedge clk);
    load_start = 1'b0;
    byte_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      byte_data = prog[i];
      @(negedge clk);
    end
    byte_valid = 1'b0;
    rst = 1'b1;
    PC = 32'd0;
    #1;
    total_cnt++;
    if (cpu_stall !== 1'b0 || byte_ready !== 1'b0
        || Instruction !== 32'h0)
      $display("FAIL midrst_in got stall=%b rdy=%b ins=%h exp 0/0/0",
               cpu_stall, byte_ready, Instruction);
    else pass_cnt++;
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      PC = 32'(4 * i);
      #1;
      total_cnt++;
      if (Instruction !== 32'h0 || cpu_stall !== 1'b0
          || byte_ready !== 1'b0)
        $display("FAIL midrst_after pc=%h got %h/%b/%b exp 0/0/0",
                 PC, Instruction, cpu_stall, byte_ready);
      else pass_cnt++;
    end
    prog[0] = 8'h01;
    prog[1] = 8'h02;
    prog[2] = 8'h03;
    prog[3] = 8'h04;
    run_load(1, 0, -1, st, dn, acc);
    @(negedge clk);
    PC = 32'd0;
    #1;
    total_cnt++;
    if (dn !== 5 || Instruction !== 32'h04030201)
      $display("FAIL midrst_reload got done=%0d ins=%h exp 5/04030201",
               dn, Instruction);
    else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_load_two();
    test_back_pressure();
    test_len_zero();
    test_len_err();
    test_full_depth();
    test_reload();
    test_reset_midload();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
